// File: rtl/dsp_chain_3_fp16_sop2_operand_loader.sv
// rtl/dsp_chain_3_fp16_sop2_operand_loader.sv - lane operand loader assembling LANES words into one bank word (optional partial-word flush: DSP_CHAIN_OPERAND_FLUSH_EN)
module dsp_chain_3_fp16_sop2_operand_loader #(
    parameter int  LANES  = 8,
    parameter int  LANE_W = 192,
    localparam int CW     = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANE_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW-1:0]           lane_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        LAST = 1'b1
    } state_t;

    state_t                  state;
    logic [LANES*LANE_W-1:0] assembly;
    logic [LANES*LANE_W-1:0] next_asm;
    logic [LANES*LANE_W-1:0] load_word;
    logic [CW:0]             fill;
    logic [CW-1:0]           next_cnt;
    logic                    accept;
    logic                    load;
    logic                    stall;

`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
    logic flush_pend;
    logic flush_pend_next;
    logic flush_req;
    logic has_data;
    logic out_free;
`else
    logic unused_flush;
    assign unused_flush = flush;
`endif

    // State is a decoded view of the lane counter: LAST when the next accept completes a word
    always_comb begin
        state = (lane_cnt == CW'(LANES - 1)) ? LAST : FILL;
    end

    // Only the completing accept waits for the output register; a pending flush holds off new lanes
    assign stall = (state == LAST) && out_valid && !out_ready;
`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
    assign in_ready = !stall && !flush_pend;
`else
    assign in_ready = !stall;
`endif

    // Datapath: merge the incoming lane into the assembly, then zero every lane not yet filled
    always_comb begin
        accept   = in_valid && in_ready;
        next_asm = assembly;
        if (accept) begin
            next_asm[lane_cnt*LANE_W +: LANE_W] = in_data;
        end
        fill      = {1'b0, lane_cnt} + {{CW{1'b0}}, accept};
        load_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(fill)) begin
                load_word[i*LANE_W +: LANE_W] = next_asm[i*LANE_W +: LANE_W];
            end
        end
    end

    // Next-state: decide whether a word launches this edge and advance or rewind the lane counter
    always_comb begin
`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
        flush_req       = flush || flush_pend;
        out_free        = !out_valid || out_ready;
        has_data        = (lane_cnt != '0) || accept;
        load            = (accept && (state == LAST)) || (flush_req && has_data && out_free);
        flush_pend_next = flush_req && has_data && !load;
`else
        load = accept && (state == LAST);
`endif
        next_cnt = lane_cnt;
        if (load) begin
            next_cnt = '0;
        end else if (accept) begin
            next_cnt = lane_cnt + CW'(1);
        end
    end

    // Registers: assembly buffer, lane counter and the output word with its full flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            assembly  <= '0;
            lane_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
            flush_pend <= 1'b0;
`endif
        end else begin
            assembly <= next_asm;
            lane_cnt <= next_cnt;
            if (load) begin
                out_data <= load_word;
            end
            out_valid <= load || (out_valid && !out_ready);
`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
            flush_pend <= flush_pend_next;
`endif
        end
    end

endmodule

// File: tb/tb_dsp_chain_3_fp16_sop2_operand_loader.sv
// tb/tb_dsp_chain_3_fp16_sop2_operand_loader.sv - randomized self-checking bench for the operand loader
module tb_dsp_chain_3_fp16_sop2_operand_loader;

    localparam int LANES  = 8;
    localparam int LANE_W = 192;
    localparam int BW     = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [LANE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [BW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        lane_cnt;

    int nvec = 0;
    int nerr = 0;

    // reference model state: lanes of the open group, output word and flag
    logic [LANE_W-1:0] grp[$];
    logic              m_ov;
    logic [BW-1:0]     m_od;
    logic              m_pend;
    logic              exp_rdy;
    logic              obs_rdy;
    logic              rst_ov;
    logic [2:0]        rst_cnt;
    logic [BW-1:0]     rst_od;
    logic              rst_rdy;

    always #5 clk = ~clk;

    dsp_chain_3_fp16_sop2_operand_loader #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane_cnt  (lane_cnt)
    );

    function automatic logic [LANE_W-1:0] rep(input logic [15:0] x);
        return {12{x}};
    endfunction

    function automatic logic [LANE_W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        grp.delete(); m_ov = 1'b0; m_od = '0; m_pend = 1'b0;
        #1;
        rst_ov = out_valid; rst_cnt = lane_cnt; rst_od = out_data;
        @(negedge clk);
        reset = 1'b1;
        #1 rst_rdy = in_ready;
    endtask

    // one clock of stimulus; the model applies the loader rules to the group queue
    task automatic step(input logic v, input logic [LANE_W-1:0] d, input logic ordy, input logic fl);
        logic          acc;
        logic          launch;
        logic [BW-1:0] w;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = ordy; flush = fl;
        exp_rdy = !((grp.size() == LANES - 1) && m_ov && !ordy) && !m_pend;
        #1 obs_rdy = in_ready;
        @(posedge clk);
        acc = v && exp_rdy;
        if (acc) grp.push_back(d);
        launch = (grp.size() == LANES);
`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
        if (!launch && (fl || m_pend) && grp.size() > 0) begin
            if (!m_ov || ordy) launch = 1'b1;
            else m_pend = 1'b1;
        end
        if (launch) m_pend = 1'b0;
`endif
        if (launch) begin
            w = '0;
            foreach (grp[i]) w[i*LANE_W +: LANE_W] = grp[i];
            m_od = w; m_ov = 1'b1;
            grp.delete();
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        nvec++;
        if (rst_ov !== 1'b0 || rst_cnt !== 3'd0 || rst_od !== '0 || rst_rdy !== 1'b1) begin
            nerr++;
            $display("FAIL reset: ov=%b cnt=%0d data_lo=%h rdy=%b, want 0 0 0 1", rst_ov, rst_cnt, rst_od[63:0], rst_rdy);
        end
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, rep(16'(k)), 1'b1, 1'b0);
            nvec++;
            if (obs_rdy !== exp_rdy || out_valid !== m_ov || lane_cnt !== 3'(grp.size()) || out_data !== m_od) begin
                nerr++;
                $display("FAIL basic k=%0d: rdy=%b/%b ov=%b/%b cnt=%0d/%0d data_lo=%h/%h", k, obs_rdy, exp_rdy, out_valid, m_ov, lane_cnt, grp.size(), out_data[63:0], m_od[63:0]);
            end
        end
        nvec++;
        if (out_valid !== 1'b1 || out_data[191:0] !== rep(16'h1) || out_data[1535:1344] !== rep(16'h8)) begin
            nerr++;
            $display("FAIL basic_word: ov=%b lane0=%h lane7=%h, want 1 and 0001.. 0008..", out_valid, out_data[63:0], out_data[1407:1344]);
        end
    endtask

    task automatic test_back_to_back();
        int   pulses[$];
        logic all_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, rnd(), 1'b1, 1'b0);
            if (out_valid === 1'b1) pulses.push_back(i);
            if (obs_rdy !== 1'b1) all_rdy = 1'b0;
            nvec++;
            if (out_valid !== m_ov || lane_cnt !== 3'(grp.size()) || out_data !== m_od) begin
                nerr++;
                $display("FAIL b2b i=%0d: ov=%b/%b cnt=%0d/%0d data_lo=%h/%h", i, out_valid, m_ov, lane_cnt, grp.size(), out_data[63:0], m_od[63:0]);
            end
        end
        nvec++;
        if (pulses.size() != 2 || pulses[0] != 8 || pulses[1] != 16 || !all_rdy) begin
            nerr++;
            $display("FAIL b2b_pulses: count=%0d rdy_held=%b, want 2 pulses at 8 and 16 with ready held", pulses.size(), all_rdy);
        end
    endtask

    task automatic test_stall();
        logic [BW-1:0] held;
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, rnd(), 1'b0, 1'b0);
        held = out_data;
        nvec++;
        if (out_valid !== 1'b1 || held !== m_od) begin
            nerr++;
            $display("FAIL stall_first: ov=%b data_lo=%h want 1 %h", out_valid, held[63:0], m_od[63:0]);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, rnd(), 1'b0, 1'b0);
            nvec++;
            if (obs_rdy !== 1'b1 || lane_cnt !== 3'(i + 1) || out_data !== held || out_valid !== 1'b1) begin
                nerr++;
                $display("FAIL stall_fill i=%0d: rdy=%b cnt=%0d ov=%b data_lo=%h want 1 %0d 1 %h", i, obs_rdy, lane_cnt, out_valid, out_data[63:0], i + 1, held[63:0]);
            end
        end
        step(1'b1, rnd(), 1'b0, 1'b0);
        nvec++;
        if (obs_rdy !== 1'b0 || lane_cnt !== 3'd7 || out_data !== held) begin
            nerr++;
            $display("FAIL stall_block: rdy=%b cnt=%0d data_lo=%h want 0 7 %h", obs_rdy, lane_cnt, out_data[63:0], held[63:0]);
        end
        step(1'b1, rnd(), 1'b1, 1'b0);
        nvec++;
        if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || lane_cnt !== 3'd0 || out_data !== m_od || out_data === held) begin
            nerr++;
            $display("FAIL stall_release: rdy=%b ov=%b cnt=%0d data_lo=%h want 1 1 0 %h", obs_rdy, out_valid, lane_cnt, out_data[63:0], m_od[63:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic ok = 1'b1;
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, rnd(), 1'b1, 1'b0);
        apply_reset();
        nvec++;
        if (rst_ov !== 1'b0 || rst_cnt !== 3'd0) begin
            nerr++;
            $display("FAIL reset_mid: ov=%b cnt=%0d want 0 0", rst_ov, rst_cnt);
        end
        for (int k = 0; k < 8; k++) step(1'b1, rep(16'(k + 16'h10)), 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) if (out_data[k*LANE_W +: LANE_W] !== rep(16'(k + 16'h10))) ok = 1'b0;
        nvec++;
        if (!ok || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL reset_clean: ov=%b data_lo=%h lanes_ok=%b want 1 %h 1", out_valid, out_data[63:0], ok, rep(16'h10));
        end
    endtask

    task automatic test_flush();
        logic [BW-1:0] w = '0;
        apply_reset();
        step(1'b1, rep(16'hA), 1'b1, 1'b0);
        step(1'b1, rep(16'hB), 1'b1, 1'b0);
        step(1'b1, rep(16'hC), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        w[191:0] = rep(16'hA); w[383:192] = rep(16'hB); w[575:384] = rep(16'hC);
        nvec++;
`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
        if (out_valid !== 1'b1 || lane_cnt !== 3'd0 || out_data !== w) begin
            nerr++;
            $display("FAIL flush_partial: ov=%b cnt=%0d data_lo=%h want 1 0 %h", out_valid, lane_cnt, out_data[63:0], w[63:0]);
        end
`else
        if (out_valid !== 1'b0 || lane_cnt !== 3'd3) begin
            nerr++;
            $display("FAIL flush_ignored: ov=%b cnt=%0d want 0 3", out_valid, lane_cnt);
        end
`endif
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b1, 1'b0);
        step(1'b1, rep(16'hD), 1'b1, 1'b1);
        nvec++;
`ifdef DSP_CHAIN_OPERAND_FLUSH_EN
        if (out_valid !== 1'b1 || lane_cnt !== 3'd0 || out_data[767:576] !== rep(16'hD) || out_data[BW-1:768] !== '0 || out_data !== m_od) begin
            nerr++;
            $display("FAIL flush_coincide: ov=%b cnt=%0d lane3=%h want 1 0 %h", out_valid, lane_cnt, out_data[639:576], rep(16'hD));
        end
`else
        if (out_valid !== 1'b0 || lane_cnt !== 3'd4) begin
            nerr++;
            $display("FAIL flush_coincide_ignored: ov=%b cnt=%0d want 0 4", out_valid, lane_cnt);
        end
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
            nvec++;
            if (obs_rdy !== exp_rdy || out_valid !== m_ov || lane_cnt !== 3'(grp.size()) || out_data !== m_od) begin
                nerr++;
                $display("FAIL random i=%0d: rdy=%b/%b ov=%b/%b cnt=%0d/%0d data_lo=%h/%h", i, obs_rdy, exp_rdy, out_valid, m_ov, lane_cnt, grp.size(), out_data[63:0], m_od[63:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        m_ov = 1'b0; m_od = '0; m_pend = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
